// File: rtl/lsu_sram_ctrl.sv
// Load/store unit driving a synchronous SRAM over a req/ack handshake, with per-access timeout.
// Optional build macro LSU_MISALIGN_CHK_EN rejects misaligned half/word accesses without touching SRAM.
module lsu_sram_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  input  logic              i_wren,
  input  logic [2:0]        i_num_byte,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_misalign,
  output logic              o_sram_req,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [3:0]        o_sram_be,
  output logic [31:0]       o_sram_wdata,
  input  logic              i_sram_ack,
  input  logic [31:0]       i_sram_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        width_q, width_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic              misalign_q, misalign_d;
  logic              sram_req_q, sram_req_d;
  logic              sram_we_q, sram_we_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [3:0]        sram_be_q, sram_be_d;
  logic [31:0]       sram_wdata_q, sram_wdata_d;

  logic [2:0]  nb;
  logic        is_b, is_h, is_w, misalign;
  logic [3:0]  be_in;
  logic [31:0] wd_in;
  logic [1:0]  lane_sel;
  logic [31:0] lane, ld_data;

  logic unused_addr;
  assign unused_addr = ^i_addr[31:ADDR_W+2];

  // Width codes 5..7 behave as a full word.
  assign nb   = (i_num_byte > 3'd4) ? 3'd4 : i_num_byte;
  assign is_w = nb[2];
  assign is_h = nb[1] & ~nb[2];
  assign is_b = ~nb[1] & ~nb[2];

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = (is_h & i_addr[0]) | (is_w & (|i_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_in = 4'b1111;
    wd_in = i_wdata;
    if (is_b) begin
      be_in = 4'b0001 << i_addr[1:0];
      wd_in = {4{i_wdata[7:0]}};
    end else if (is_h) begin
      be_in = 4'b0011 << {i_addr[1], 1'b0};
      wd_in = {2{i_wdata[15:0]}};
    end
  end

  // Load lane select mirrors the byte-enable alignment used for the request.
  always_comb begin
    lane_sel = 2'b00;
    if (width_q[2:1] == 2'b00)      lane_sel = addr_lo_q;
    else if (width_q[2:1] == 2'b01) lane_sel = {addr_lo_q[1], 1'b0};
    lane = i_sram_rdata >> {lane_sel, 3'b000};
    unique case (width_q)
      3'd0:    ld_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ld_data = {24'd0, lane[7:0]};
      3'd2:    ld_data = {{16{lane[15]}}, lane[15:0]};
      3'd3:    ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    width_d      = width_q;
    rdata_d      = rdata_q;
    timeout_d    = timeout_q;
    misalign_d   = misalign_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_be_d    = sram_be_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      StIdle: begin
        if (i_req) begin
          addr_lo_d = i_addr[1:0];
          width_d   = nb;
          timeout_d = 1'b0;
          cnt_d     = '0;
          if (misalign) begin
            misalign_d = 1'b1;
            rdata_d    = '0;
            state_d    = StDone;
          end else begin
            misalign_d   = 1'b0;
            sram_req_d   = 1'b1;
            sram_we_d    = i_wren;
            sram_addr_d  = i_addr[ADDR_W+1:2];
            sram_be_d    = be_in;
            sram_wdata_d = wd_in;
            state_d      = StWait;
          end
        end
      end
      StWait: begin
        if (i_sram_ack) begin
          sram_req_d = 1'b0;
          rdata_d    = sram_we_q ? 32'd0 : ld_data;
          state_d    = StDone;
        end else if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
          sram_req_d = 1'b0;
          rdata_d    = '0;
          timeout_d  = 1'b1;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        timeout_d  = 1'b0;
        misalign_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_lo_q    <= '0;
      width_q      <= '0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
      misalign_q   <= 1'b0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_be_q    <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      width_q      <= width_d;
      rdata_q      <= rdata_d;
      timeout_q    <= timeout_d;
      misalign_q   <= misalign_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_be_q    <= sram_be_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign o_stall      = ((state_q == StIdle) && i_req) || (state_q == StWait);
  assign o_done       = (state_q == StDone);
  assign o_timeout    = (state_q == StDone) && timeout_q;
  assign o_misalign   = (state_q == StDone) && misalign_q;
  assign o_rdata      = rdata_q;
  assign o_sram_req   = sram_req_q;
  assign o_sram_we    = sram_we_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_be    = sram_be_q;
  assign o_sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// Directed bench for lsu_sram_ctrl: drives accesses cycle by cycle on the falling edge.
module tb_lsu_sram_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic        i_wren = 1'b0;
  logic [2:0]  i_num_byte = 3'd0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_stall, o_done, o_timeout, o_misalign;
  logic        o_sram_req, o_sram_we;
  logic [17:0] o_sram_addr;
  logic [3:0]  o_sram_be;
  logic [31:0] o_sram_wdata;
  logic        i_sram_ack = 1'b0;
  logic [31:0] i_sram_rdata = '0;

  lsu_sram_ctrl dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_wren       (i_wren),
    .i_num_byte   (i_num_byte),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_stall      (o_stall),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_misalign   (o_misalign),
    .o_sram_req   (o_sram_req),
    .o_sram_we    (o_sram_we),
    .o_sram_addr  (o_sram_addr),
    .o_sram_be    (o_sram_be),
    .o_sram_wdata (o_sram_wdata),
    .i_sram_ack   (i_sram_ack),
    .i_sram_rdata (i_sram_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;

  // Results captured by run_access.
  int          done_cyc, stall_cnt;
  logic        saw_req, req_at_done, to_seen, mis_seen, cap_we;
  logic [31:0] rd_seen, cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Holds i_req until o_done; ack_cyc < 0 means never acknowledge.
  task automatic run_access(input logic wren, input logic [2:0] nb, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_cyc,
                            input logic [31:0] rdata);
    done_cyc = -1; stall_cnt = 0; saw_req = 0; req_at_done = 1;
    to_seen = 0; mis_seen = 0; rd_seen = '0; cap_we = 0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge i_clk);
      i_req = 1'b1; i_wren = wren; i_num_byte = nb; i_addr = addr; i_wdata = wdata;
      i_sram_ack = (c == ack_cyc); i_sram_rdata = rdata;
      #1;
      if (o_stall) stall_cnt++;
      if (o_sram_req && !saw_req) begin
        saw_req = 1; cap_we = o_sram_we; cap_addr = 32'(o_sram_addr);
        cap_be = o_sram_be; cap_wdata = o_sram_wdata;
      end
      if (o_done) begin
        done_cyc = c; rd_seen = o_rdata; to_seen = o_timeout; mis_seen = o_misalign;
        req_at_done = o_sram_req;
        i_req = 1'b0; i_sram_ack = 1'b0;
        break;
      end
    end
    i_req = 1'b0; i_sram_ack = 1'b0;
    if (done_cyc < 0) check("access_bound", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    #1;
    check("rst_sram_req", 32'(o_sram_req), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_be", 32'(o_sram_be), 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;

    run_access(1'b1, 3'd4, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    check("sw_done_cyc", 32'(done_cyc), 32'd2);
    check("sw_addr", cap_addr, 32'h40);
    check("sw_be", 32'(cap_be), 32'hF);
    check("sw_we", 32'(cap_we), 32'd1);
    check("sw_wdata", cap_wdata, 32'hDEADBEEF);
    check("sw_stall", 32'(stall_cnt), 32'd2);
    check("sw_rdata", rd_seen, 32'd0);

    run_access(1'b0, 3'd0, 32'h103, 32'h0, 3, 32'h80112233);
    check("lb_done_cyc", 32'(done_cyc), 32'd4);
    check("lb_rdata", rd_seen, 32'hFFFFFF80);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_we", 32'(cap_we), 32'd0);
    run_access(1'b0, 3'd1, 32'h103, 32'h0, 1, 32'h80112233);
    check("lbu_rdata", rd_seen, 32'h00000080);

    run_access(1'b1, 3'd2, 32'h202, 32'h0000ABCD, 1, 32'h0);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("sh_addr", cap_addr, 32'h80);
    run_access(1'b0, 3'd3, 32'h202, 32'h0, 1, 32'hABCD0000);
    check("lhu_rdata", rd_seen, 32'h0000ABCD);
    run_access(1'b0, 3'd2, 32'h202, 32'h0, 1, 32'hABCD0000);
    check("lh_rdata", rd_seen, 32'hFFFFABCD);

    run_access(1'b1, 3'd0, 32'h001, 32'h1234565A, 1, 32'h0);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'h5A5A5A5A);
    run_access(1'b0, 3'd7, 32'h0, 32'h0, 1, 32'h12345678);
    check("lw7_rdata", rd_seen, 32'h12345678);
    check("lw7_be", 32'(cap_be), 32'hF);

    // Stray ack while idle must not start or finish anything.
    @(negedge i_clk); i_sram_ack = 1'b1; #1;
    check("idle_ack_stall", 32'(o_stall), 32'd0);
    @(negedge i_clk); i_sram_ack = 1'b0; #1;
    check("idle_ack_done", 32'(o_done), 32'd0);
    check("idle_ack_req", 32'(o_sram_req), 32'd0);

    run_access(1'b0, 3'd4, 32'h10, 32'h0, -1, 32'hCAFEF00D);
    check("to_done_cyc", 32'(done_cyc), 32'd256);
    check("to_flag", 32'(to_seen), 32'd1);
    check("to_rdata", rd_seen, 32'd0);
    check("to_req_dropped", 32'(req_at_done), 32'd0);
    check("to_stall", 32'(stall_cnt), 32'd256);

    run_access(1'b0, 3'd4, 32'h10, 32'h0, 255, 32'hCAFEF00D);
    check("ackto_done_cyc", 32'(done_cyc), 32'd256);
    check("ackto_flag", 32'(to_seen), 32'd0);
    check("ackto_rdata", rd_seen, 32'hCAFEF00D);

    // Reset while in WAIT.
    @(negedge i_clk); i_req = 1'b1; i_wren = 1'b0; i_num_byte = 3'd4; i_addr = 32'h20;
    @(negedge i_clk); #1;
    check("mid_in_wait_req", 32'(o_sram_req), 32'd1);
    i_rst_n = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1; i_req = 1'b0; #1;
    check("mid_rst_req", 32'(o_sram_req), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    check("mid_rst_stall", 32'(o_stall), 32'd0);
    @(negedge i_clk); #1;
    check("mid_rst_done2", 32'(o_done), 32'd0);
    run_access(1'b0, 3'd4, 32'h20, 32'h0, 1, 32'h0BADF00D);
    check("post_rst_done_cyc", 32'(done_cyc), 32'd2);
    check("post_rst_rdata", rd_seen, 32'h0BADF00D);

    run_access(1'b0, 3'd4, 32'h101, 32'h0, 1, 32'h55AA55AA);
`ifdef LSU_MISALIGN_CHK_EN
    check("mis_done_cyc", 32'(done_cyc), 32'd1);
    check("mis_flag", 32'(mis_seen), 32'd1);
    check("mis_no_req", 32'(saw_req), 32'd0);
    check("mis_stall", 32'(stall_cnt), 32'd1);
    check("mis_rdata", rd_seen, 32'd0);
`else
    check("mis_done_cyc", 32'(done_cyc), 32'd2);
    check("mis_flag", 32'(mis_seen), 32'd0);
    check("mis_addr", cap_addr, 32'h40);
    check("mis_be", 32'(cap_be), 32'hF);
    check("mis_rdata", rd_seen, 32'h55AA55AA);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
